// File: rtl/alu_sequencer_if.sv
// Command/result port between the ALU sequencer (master) and the CPU datapath (slave).
interface alu_sequencer_if;
  logic       cpu_ce;
  logic       cpu_load;
  logic [7:0] cpu_opcode;
  logic [7:0] cpu_data_in;
  logic       cpu_cin;
  logic [7:0] cpu_data_out;

  modport master (
    output cpu_ce, cpu_load, cpu_opcode, cpu_data_in, cpu_cin,
    input  cpu_data_out
  );

  modport slave (
    input  cpu_ce, cpu_load, cpu_opcode, cpu_data_in, cpu_cin,
    output cpu_data_out
  );
endinterface

// File: rtl/alu_sequencer.sv
// Program-driven controller: fetches 16-bit words from a synchronous program
// memory and issues single-cycle load/operation commands to the CPU datapath.
module alu_sequencer #(
  parameter int PROG_AW = 5,
  parameter int OP_LAT  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [PROG_AW-1:0] prog_addr,
  input  logic [15:0]        prog_data,
  alu_sequencer_if.master    cpu,
  output logic [7:0]         result,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_t;

  localparam logic [PROG_AW-1:0] PC_LAST  = '1;
  localparam logic [3:0]         CNT_INIT = 4'(OP_LAT - 1);

  state_t             state, state_nx;
  logic [PROG_AW-1:0] pc, pc_nx;
  logic [3:0]         cnt, cnt_nx;
  logic               ce_nx, load_nx, cin_nx, err_nx, advance;
  logic [7:0]         opcode_nx, din_nx, result_nx;

  // pc is itself the registered program address, so FETCH presents it directly.
  assign prog_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    cnt_nx    = cnt;
    ce_nx     = 1'b0;
    load_nx   = cpu.cpu_load;
    opcode_nx = cpu.cpu_opcode;
    din_nx    = cpu.cpu_data_in;
    cin_nx    = cpu.cpu_cin;
    result_nx = result;
    err_nx    = err;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pc_nx    = '0;
          err_nx   = 1'b0;
          state_nx = FETCH;
        end
      end
      FETCH: state_nx = ISSUE;
      ISSUE: begin
        case (prog_data[15:14])
          2'b00: advance = 1'b1;
          2'b01: begin
            ce_nx     = 1'b1;
            load_nx   = 1'b1;
            opcode_nx = {1'b0, prog_data[13:11], 4'b0000};
            din_nx    = prog_data[7:0];
            advance   = 1'b1;
          end
          2'b10: begin
            ce_nx     = 1'b1;
            load_nx   = 1'b0;
            opcode_nx = {1'b0, prog_data[13:11], prog_data[10:7]};
            cin_nx    = prog_data[6];
            cnt_nx    = CNT_INIT;
            state_nx  = WAIT;
          end
          default: state_nx = DONE;
        endcase
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          result_nx = cpu.cpu_data_out;
          advance   = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // The last program word never wraps back to 0; running off it is an error.
    if (advance) begin
      if (pc == PC_LAST) begin
        err_nx   = 1'b1;
        state_nx = DONE;
      end else begin
        pc_nx    = pc + 1'b1;
        state_nx = FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc              <= '0;
      cnt             <= '0;
      cpu.cpu_ce      <= 1'b0;
      cpu.cpu_load    <= 1'b0;
      cpu.cpu_opcode  <= '0;
      cpu.cpu_data_in <= '0;
      cpu.cpu_cin     <= 1'b0;
      result          <= '0;
      err             <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      pc              <= pc_nx;
      cnt             <= cnt_nx;
      cpu.cpu_ce      <= ce_nx;
      cpu.cpu_load    <= load_nx;
      cpu.cpu_opcode  <= opcode_nx;
      cpu.cpu_data_in <= din_nx;
      cpu.cpu_cin     <= cin_nx;
      result          <= result_nx;
      err             <= err_nx;
      busy            <= (state_nx != IDLE);
      done            <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (OP_LAT 3 and 1) driven from one program
// memory, checked cycle by cycle against a timeline model of the instruction set.
module tb_alu_sequencer;
  localparam int MAXC = 256;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sel = 1'b0;
  logic [7:0] dout_v = 8'h00;
  always #5 clk = ~clk;

  logic [15:0] mem [32];
  alu_sequencer_if if0();
  alu_sequencer_if if1();
  logic [4:0]  pa0, pa1;
  logic [15:0] pd0, pd1;
  logic [7:0]  res0, res1;
  logic busy0, busy1, done0, done1, err0, err1, st0, st1;

  assign st0 = start & ~sel;
  assign st1 = start & sel;
  assign if0.cpu_data_out = dout_v;
  assign if1.cpu_data_out = dout_v;

  always @(posedge clk) begin
    pd0 <= mem[pa0];
    pd1 <= mem[pa1];
  end

  alu_sequencer #(.PROG_AW(5), .OP_LAT(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .prog_addr(pa0), .prog_data(pd0),
    .cpu(if0), .result(res0), .busy(busy0), .done(done0), .err(err0));
  alu_sequencer #(.PROG_AW(5), .OP_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .prog_addr(pa1), .prog_data(pd1),
    .cpu(if1), .result(res1), .busy(busy1), .done(done1), .err(err1));

  // view of whichever instance is under test
  logic [4:0] v_pa;
  logic       v_ce, v_load, v_cin, v_busy, v_done, v_err;
  logic [7:0] v_op, v_din, v_res;
  always_comb begin
    if (sel) begin
      v_pa = pa1; v_ce = if1.cpu_ce; v_load = if1.cpu_load; v_cin = if1.cpu_cin;
      v_op = if1.cpu_opcode; v_din = if1.cpu_data_in; v_res = res1;
      v_busy = busy1; v_done = done1; v_err = err1;
    end else begin
      v_pa = pa0; v_ce = if0.cpu_ce; v_load = if0.cpu_load; v_cin = if0.cpu_cin;
      v_op = if0.cpu_opcode; v_din = if0.cpu_data_in; v_res = res0;
      v_busy = busy0; v_done = done0; v_err = err0;
    end
  end

  int total = 0, bad = 0;
  int obs_ce[$];
  int obs_done[$];
  logic [7:0] obs_res [MAXC];
  logic [7:0] dtab [MAXC];

  // expected per-cycle outputs; cycle 0 is the cycle start is presented
  logic       e_ce [MAXC], e_busy [MAXC], e_done [MAXC], e_err [MAXC];
  logic       e_load [MAXC], e_cin [MAXC];
  logic [7:0] e_op [MAXC], e_din [MAXC], e_res [MAXC];
  // values each instance holds between programs
  logic       h_load [2], h_cin [2], h_err [2];
  logic [7:0] h_op [2], h_din [2], h_res [2];

  function automatic logic [15:0] w_load(input int r, input logic [7:0] imm);
    return {2'b01, 3'(r), 3'b000, imm};
  endfunction
  function automatic logic [15:0] w_exec(input int r, input int op, input logic c);
    return {2'b10, 3'(r), 4'(op), c, 6'b000000};
  endfunction

  task automatic clear_held();
    for (int s = 0; s < 2; s++) begin
      h_load[s] = 0; h_cin[s] = 0; h_err[s] = 0; h_op[s] = 0; h_din[s] = 0; h_res[s] = 0;
    end
  endtask

  // Walks the program at instruction granularity: FETCH/ISSUE take two cycles,
  // an EXEC adds lat WAIT cycles, command outputs appear the cycle after ISSUE.
  task automatic build_model(input int lat, input int s, output int dcyc);
    int t, pc, cap;
    logic [15:0] w;
    logic ferr;
    for (int k = 0; k < MAXC; k++) begin
      e_ce[k] = 0; e_busy[k] = 0; e_done[k] = 0; e_err[k] = h_err[s];
      e_load[k] = h_load[s]; e_cin[k] = h_cin[s]; e_op[k] = h_op[s];
      e_din[k] = h_din[s]; e_res[k] = h_res[s];
    end
    t = 1; pc = 0; ferr = 0; dcyc = -1;
    while (dcyc < 0) begin
      w = mem[pc];
      case (w[15:14])
        2'b00: t += 2;
        2'b01: begin
          e_ce[t+2] = 1;
          for (int c = t + 2; c < MAXC; c++) begin
            e_load[c] = 1; e_op[c] = {1'b0, w[13:11], 4'b0000}; e_din[c] = w[7:0];
          end
          t += 2;
        end
        2'b10: begin
          e_ce[t+2] = 1;
          for (int c = t + 2; c < MAXC; c++) begin
            e_load[c] = 0; e_op[c] = {1'b0, w[13:11], w[10:7]}; e_cin[c] = w[6];
          end
          cap = t + 1 + lat;
          for (int c = cap + 1; c < MAXC; c++) e_res[c] = dtab[cap];
          t += 2 + lat;
        end
        default: dcyc = t + 2;
      endcase
      if (dcyc < 0) begin
        if (pc == 31) begin ferr = 1; dcyc = t; end
        else pc++;
      end
    end
    for (int c = 1; c < MAXC; c++) begin
      e_busy[c] = (c <= dcyc);
      e_err[c]  = (c < dcyc) ? 1'b0 : ferr;
    end
    e_done[dcyc] = 1;
    h_load[s] = e_load[MAXC-1]; h_cin[s] = e_cin[MAXC-1]; h_op[s] = e_op[MAXC-1];
    h_din[s] = e_din[MAXC-1]; h_res[s] = e_res[MAXC-1]; h_err[s] = ferr;
  endtask

  // Runs the loaded program on the selected instance; extra = cycle of a stray
  // start pulse, rcyc = cycle in which rst_n is pulled low (-1 for none).
  task automatic run_prog(input int extra, input int rcyc);
    int dcyc, s, lat;
    s = sel ? 1 : 0;
    lat = sel ? 1 : 3;
    for (int k = 0; k < MAXC; k++) dtab[k] = 8'($urandom);
    build_model(lat, s, dcyc);
    obs_ce.delete();
    obs_done.delete();
    @(posedge clk); #1;
    for (int k = 0; k <= dcyc + 2; k++) begin
      start = (k == 0) || (k == extra);
      dout_v = dtab[k];
      @(negedge clk);
      total += 9;
      if (v_busy !== e_busy[k]) begin bad++; $display("FAIL busy cyc=%0d got=%b exp=%b", k, v_busy, e_busy[k]); end
      if (v_done !== e_done[k]) begin bad++; $display("FAIL done cyc=%0d got=%b exp=%b", k, v_done, e_done[k]); end
      if (v_ce !== e_ce[k]) begin bad++; $display("FAIL cpu_ce cyc=%0d got=%b exp=%b", k, v_ce, e_ce[k]); end
      if (v_err !== e_err[k]) begin bad++; $display("FAIL err cyc=%0d got=%b exp=%b", k, v_err, e_err[k]); end
      if (v_res !== e_res[k]) begin bad++; $display("FAIL result cyc=%0d got=%h exp=%h", k, v_res, e_res[k]); end
      if (v_load !== e_load[k]) begin bad++; $display("FAIL cpu_load cyc=%0d got=%b exp=%b", k, v_load, e_load[k]); end
      if (v_op !== e_op[k]) begin bad++; $display("FAIL cpu_opcode cyc=%0d got=%h exp=%h", k, v_op, e_op[k]); end
      if (v_din !== e_din[k]) begin bad++; $display("FAIL cpu_data_in cyc=%0d got=%h exp=%h", k, v_din, e_din[k]); end
      if (v_cin !== e_cin[k]) begin bad++; $display("FAIL cpu_cin cyc=%0d got=%b exp=%b", k, v_cin, e_cin[k]); end
      if (v_ce) obs_ce.push_back(k);
      if (v_done) obs_done.push_back(k);
      obs_res[k] = v_res;
      if (k == rcyc) begin
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({v_pa, v_ce, v_load, v_op, v_din, v_cin, v_res, v_busy, v_done, v_err} !== 35'd0) begin
          bad++;
          $display("FAIL async_reset cyc=%0d got=%h exp=0", k,
                   {v_pa, v_ce, v_load, v_op, v_din, v_cin, v_res, v_busy, v_done, v_err});
        end
        start = 1'b0;
        clear_held();
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic load_plan_program();
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    mem[0] = w_load(1, 8'h05);
    mem[1] = w_load(2, 8'h03);
    mem[2] = w_exec(2, 1, 1'b0);
    mem[3] = 16'hC000;
  endtask

  task automatic test_reset();
    clear_held();
    rst_n = 1'b0;
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      total++;
      if ({v_pa, v_ce, v_load, v_op, v_din, v_cin, v_res, v_busy, v_done, v_err} !== 35'd0) begin
        bad++;
        $display("FAIL reset_state inst=%0d got=%h exp=0", s,
                 {v_pa, v_ce, v_load, v_op, v_din, v_cin, v_res, v_busy, v_done, v_err});
      end
    end
    sel = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_program();
    sel = 1'b0;
    load_plan_program();
    run_prog(-1, -1);
    // command registers load at the end of ISSUE cycles 2, 4, 6
    total += 3;
    if (obs_ce.size() != 3 || obs_ce[0] != 3 || obs_ce[1] != 5 || obs_ce[2] != 7) begin
      bad++; $display("FAIL plan_strobes got=%p exp={3,5,7}", obs_ce);
    end
    if (obs_done.size() != 1 || obs_done[0] != 12) begin
      bad++; $display("FAIL plan_done got=%p exp={12}", obs_done);
    end
    if (obs_res[10] !== dtab[9]) begin
      bad++; $display("FAIL plan_result got=%h exp=%h", obs_res[10], dtab[9]);
    end
  endtask

  task automatic test_halt_only();
    sel = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hC000 | 16'($urandom_range(0, 16'h3FFF));
    run_prog(-1, -1);
    total += 2;
    if (obs_ce.size() != 0) begin bad++; $display("FAIL halt_no_strobe got=%0d exp=0", obs_ce.size()); end
    if (obs_done.size() != 1 || obs_done[0] != 3) begin
      bad++; $display("FAIL halt_done got=%p exp={3}", obs_done);
    end
  endtask

  task automatic test_run_off_end();
    sel = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = {2'b00, 14'($urandom)};
    run_prog(-1, -1);
    total += 2;
    if (obs_done.size() != 1 || obs_done[0] != 65) begin
      bad++; $display("FAIL end_done got=%p exp={65}", obs_done);
    end
    if (v_err !== 1'b1) begin bad++; $display("FAIL end_err got=%b exp=1", v_err); end
    mem[0] = 16'hC000;
    run_prog(-1, -1);
    total++;
    if (v_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", v_err); end
  endtask

  task automatic test_start_during_wait();
    sel = 1'b0;
    load_plan_program();
    run_prog(8, -1);
    total += 2;
    if (obs_done.size() != 1 || obs_done[0] != 12) begin
      bad++; $display("FAIL wait_start_done got=%p exp={12}", obs_done);
    end
    if (obs_ce.size() != 3) begin bad++; $display("FAIL wait_start_strobes got=%0d exp=3", obs_ce.size()); end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    load_plan_program();
    run_prog(-1, 8);
    run_prog(-1, -1);
    total++;
    if (obs_done.size() != 1 || obs_done[0] != 12) begin
      bad++; $display("FAIL rerun_done got=%p exp={12}", obs_done);
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) mem[i] = w_exec($urandom_range(0, 7), $urandom_range(0, 15), 1'($urandom));
    mem[4] = 16'hC000;
    run_prog(-1, -1);
    total++;
    if (obs_ce.size() != 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", obs_ce.size()); end
    for (int i = 1; i < obs_ce.size(); i++) begin
      total++;
      if (obs_ce[i] - obs_ce[i-1] != 3) begin
        bad++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=3", i, obs_ce[i] - obs_ce[i-1]);
      end
    end
    foreach (obs_ce[i]) begin
      total++;
      if (obs_res[obs_ce[i] + 1] !== dtab[obs_ce[i]]) begin
        bad++; $display("FAIL b2b_result idx=%0d got=%h exp=%h", i, obs_res[obs_ce[i] + 1], dtab[obs_ce[i]]);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      sel = it[0];
      for (int i = 0; i < 32; i++) begin
        mem[i] = 16'($urandom);
        // bias two runs towards long programs with no HALT
        if (it >= 6 && mem[i][15:14] == 2'b11) mem[i][15] = 1'b0;
      end
      run_prog(-1, -1);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_program();
    test_halt_only();
    test_run_off_end();
    test_start_during_wait();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
